// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer for a valid/ready pipeline stage.
// All outputs come straight from flops: the skid register absorbs the single
// beat that may arrive in the cycle in which downstream stalls.
// Optional feature: define PIPE_SKID_FLUSH_EN to add the flush input, which
// empties the buffer. In the default build the port is absent and flush is
// held at 0.
module pipe_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_out_data;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_count;

    logic               w_flush;
    logic               w_accept;
    logic               w_pop;

`ifdef PIPE_SKID_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Handshakes are qualified by the registered ready/valid the block presents
    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    // State machine with registered handshake outputs and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_data  <= '0;
            r_skid_data <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_count     <= CNT_W'(0);
        end else if (w_flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_count     <= CNT_W'(0);
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= BUSY;
                        r_out_data  <= in_data;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_count     <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (w_accept && !w_pop) begin
                        // Downstream stalled: park the new beat in the skid reg
                        r_state     <= FULL;
                        r_skid_data <= in_data;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_count     <= CNT_W'(2);
                    end else if (w_pop && !w_accept) begin
                        r_state     <= EMPTY;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_count     <= CNT_W'(0);
                    end else if (w_pop && w_accept) begin
                        r_out_data  <= in_data;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state     <= BUSY;
                        r_out_data  <= r_skid_data;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_count     <= CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_count     <= CNT_W'(0);
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer at WIDTH=8, plus a queue-model random run.
module tb_pipe_skid_buffer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int checks;
    int failures;

    pipe_skid_buffer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'hFF; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill1_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL fill1_out_data got=%h exp=a5", out_data); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL fill1_count got=%0d exp=1", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill1_in_ready got=%b exp=1", in_ready); end
        in_data = 8'h3C;
        step();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL fill2_count got=%0d exp=2", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill2_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL fill2_out_data got=%h exp=a5", out_data); end
        // Offered beat while FULL must be ignored; output must hold under stall
        in_data = 8'h99;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL stall_out_data got=%h exp=a5", out_data); end
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", count); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL drain0_out_data got=%h exp=a5", out_data); end
        step();
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL drain1_count got=%0d exp=1", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain1_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL drain1_out_data got=%h exp=3c", out_data); end
        step();
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL drain2_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain2_out_valid got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            v = W'(i);
            in_data = v;
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== v) begin
                failures++; $display("FAIL stream_beat%0d got_v=%b got_d=%h exp_d=%h", i, out_valid, out_data, v);
            end
            checks++; if (count !== 2'd1) begin failures++; $display("FAIL stream_count%0d got=%0d exp=1", i, count); end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL stream_end got_cnt=%0d got_v=%b exp_cnt=0 exp_v=0", count, out_valid);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        int popped;
        int cycles;
        int bad;
        logic acc, pp;
        popped = 0; cycles = 0; bad = 0;
        while (popped < 1000 && cycles < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            // Compare the presented outputs with the queue model
            checks++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) ||
                count !== 2'(q.size()) || (q.size() > 0 && out_data !== q[0])) begin
                failures++; bad++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d got_rdy=%b got_v=%b got_cnt=%0d got_d=%h exp_cnt=%0d exp_d=%h",
                             cycles, in_ready, out_valid, count, out_data, q.size(),
                             (q.size() > 0) ? q[0] : 8'h00);
            end
            checks++;
            if (count === 2'd2 && in_ready === 1'b1) begin
                failures++; $display("FAIL random_ready_full cycle=%0d got_rdy=1 exp_rdy=0", cycles);
            end
            acc = in_valid && (q.size() < 2);
            pp  = out_ready && (q.size() > 0);
            step();
            cycles++;
            if (pp) begin void'(q.pop_front()); popped++; end
            if (acc) q.push_back(in_data);
        end
        checks++; if (popped < 1000) begin failures++; $display("FAIL random_timeout got=%0d exp=1000", popped); end
        // Drain what is left
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL random_drain_count got=%0d exp=0", count); end
    endtask

    task automatic fill_full();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset_full();
        fill_full();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL rstfull_pre_count got=%0d exp=2", count); end
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL rstfull_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstfull_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstfull_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rstfull_out_data got=%h exp=00", out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstfull_discard got=%b exp=0", out_valid); end
        // Skid reg must be cleared too: a single new beat shows with no leftover
        in_valid = 1'b1; in_data = 8'h5A; step();
        in_valid = 1'b0; out_ready = 1'b1; step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL rstfull_after_count got=%0d exp=0", count); end
    endtask

`ifdef PIPE_SKID_FLUSH_EN
    task automatic test_flush();
        fill_full();
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h66;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got=%b exp=0", out_valid); end
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_full();
`ifdef PIPE_SKID_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
